// File: rtl/sync_blank_gen.sv
// Resamples raw core sync on a pixel-enable grid, measures line/frame timing,
// generates blanking/DE and a frame-height lock indicator.
module sync_blank_gen #(
    parameter int PIX_DIV     = 16,
    parameter int CNT_W       = 16,
    parameter int LOCK_FRAMES = 3,
    parameter int SYNC_POL    = 1
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             hs_in,
    input  logic             vs_in,
    input  logic [CNT_W-1:0] hb_start,
    input  logic [CNT_W-1:0] hb_end,
    input  logic [CNT_W-1:0] vb_start,
    input  logic [CNT_W-1:0] vb_end,
    output logic             ce_pix,
    output logic             hsync,
    output logic             vsync,
    output logic             hblank,
    output logic             vblank,
    output logic             de,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic [CNT_W-1:0] line_len,
    output logic [CNT_W-1:0] frame_lines,
    output logic             frame_start,
    output logic             locked
);

    localparam int               DIV_W    = (PIX_DIV > 2) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic             ACT      = (SYNC_POL != 0);
    localparam logic [3:0]       LOCK_N   = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_e;

    logic [DIV_W-1:0] div_q, div_d;
    logic             ce_q, ce_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    logic [CNT_W-1:0] line_len_q, line_len_d;
    logic [CNT_W-1:0] frame_lines_q, frame_lines_d;
    logic             fs_q, fs_d;
    logic             hblank_q, hblank_d;
    logic             vblank_q, vblank_d;
    logic             de_q, de_d;
    state_e           state_q, state_d;
    logic [3:0]       match_q, match_d;
    logic [3:0]       match_inc;
    logic [CNT_W-1:0] ref_q, ref_d;

    logic tick;
    logic hs_s, vs_s;
    logic hs_rise, vs_rise;
    logic timeout;

    assign tick    = (div_q == DIV_LAST);
    assign hs_s    = (hs_in == ACT);
    assign vs_s    = (vs_in == ACT);
    assign hs_rise = hs_s & ~hsync_q;
    assign vs_rise = vs_s & ~vsync_q;
    assign timeout = (hcnt_d == CNT_MAX) | (vcnt_d == CNT_MAX);

    always_comb begin
        div_d         = tick ? '0 : div_q + 1'b1;
        ce_d          = tick;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;
        fs_d          = fs_q;
        hblank_d      = hblank_q;
        vblank_d      = vblank_q;
        de_d          = de_q;
        if (tick) begin
            hsync_d = hs_s;
            fs_d    = 1'b0;
            if (hs_rise) begin
                hcnt_d = '0;
                if (hcnt_q != CNT_MAX) line_len_d = hcnt_q + 1'b1;
                if (vcnt_q != CNT_MAX) vcnt_d = vcnt_q + 1'b1;
                vsync_d = vs_s;
                if (vs_rise) begin
                    vcnt_d = '0;
                    if (vcnt_q != CNT_MAX) frame_lines_d = vcnt_q + 1'b1;
                    fs_d = 1'b1;
                end
            end else if (hcnt_q != CNT_MAX) begin
                hcnt_d = hcnt_q + 1'b1;
            end
            hblank_d = (hcnt_d >= hb_start) | (hcnt_d < hb_end);
            vblank_d = (vcnt_d >= vb_start) | (vcnt_d < vb_end);
            de_d     = ~(hblank_d | vblank_d);
        end
    end

    // Lock tracking acts on the values being registered this tick.
    assign match_inc = match_q + 1'b1;

    always_comb begin
        state_d = state_q;
        match_d = match_q;
        ref_d   = ref_q;
        if (tick) begin
            if (timeout) begin
                state_d = SEARCH;
                match_d = '0;
            end else if (fs_d) begin
                unique case (state_q)
                    SEARCH: begin
                        state_d = TRACK;
                        match_d = '0;
                    end
                    TRACK: begin
                        if (frame_lines_d == ref_q) begin
                            match_d = match_inc;
                        end else begin
                            ref_d   = frame_lines_d;
                            match_d = 4'd1;
                        end
                        if (match_d >= LOCK_N) state_d = LOCKED;
                    end
                    LOCKED: begin
                        if (frame_lines_d != ref_q) begin
                            state_d = TRACK;
                            ref_d   = frame_lines_d;
                            match_d = 4'd1;
                        end
                    end
                    default: begin
                        state_d = SEARCH;
                        match_d = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            div_q         <= '0;
            ce_q          <= 1'b0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            fs_q          <= 1'b0;
            hblank_q      <= 1'b1;
            vblank_q      <= 1'b1;
            de_q          <= 1'b0;
            state_q       <= SEARCH;
            match_q       <= '0;
            ref_q         <= '0;
        end else begin
            div_q         <= div_d;
            ce_q          <= ce_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            fs_q          <= fs_d;
            hblank_q      <= hblank_d;
            vblank_q      <= vblank_d;
            de_q          <= de_d;
            state_q       <= state_d;
            match_q       <= match_d;
            ref_q         <= ref_d;
        end
    end

    assign ce_pix      = ce_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign hcnt        = hcnt_q;
    assign vcnt        = vcnt_q;
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
    assign frame_start = fs_q;
    assign hblank      = hblank_q;
    assign vblank      = vblank_q;
    assign de          = de_q;
    assign locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_sync_blank_gen.sv
// Randomized frame-timing bench for sync_blank_gen against a tick-level
// reference model built from elapsed tick/line counts.
module tb_sync_blank_gen;

    localparam int PIX_DIV     = 4;
    localparam int CNT_W       = 10;
    localparam int LOCK_FRAMES = 3;
    localparam int SYNC_POL    = 0;
    localparam int MAXC        = (1 << CNT_W) - 1;

    logic             clk_sys = 1'b0;
    logic             reset_n = 1'b0;
    logic             hs_in   = 1'b1;
    logic             vs_in   = 1'b1;
    logic [CNT_W-1:0] hb_start, hb_end, vb_start, vb_end;
    logic             ce_pix, hsync, vsync, hblank, vblank, de;
    logic [CNT_W-1:0] hcnt, vcnt, line_len, frame_lines;
    logic             frame_start, locked;

    sync_blank_gen #(
        .PIX_DIV    (PIX_DIV),
        .CNT_W      (CNT_W),
        .LOCK_FRAMES(LOCK_FRAMES),
        .SYNC_POL   (SYNC_POL)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .hs_in      (hs_in),
        .vs_in      (vs_in),
        .hb_start   (hb_start),
        .hb_end     (hb_end),
        .vb_start   (vb_start),
        .vb_end     (vb_end),
        .ce_pix     (ce_pix),
        .hsync      (hsync),
        .vsync      (vsync),
        .hblank     (hblank),
        .vblank     (vblank),
        .de         (de),
        .hcnt       (hcnt),
        .vcnt       (vcnt),
        .line_len   (line_len),
        .frame_lines(frame_lines),
        .frame_start(frame_start),
        .locked     (locked)
    );

    always #5 clk_sys = ~clk_sys;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: ticks since last hs rise, lines since last vs rise.
    int th, lv, m_ll, m_fl, run, last_h;
    bit hp, vp, m_fs, srch;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clampc(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    task automatic model_reset();
        th = 0; lv = 0; m_ll = 0; m_fl = 0;
        hp = 0; vp = 0; m_fs = 0; srch = 1;
        run = 0; last_h = -1;
    endtask

    task automatic model_tick(input bit hs, input bit vs);
        bit rise, vr;
        rise = hs && !hp;
        hp   = hs;
        m_fs = 0;
        if (rise) begin
            if (th < MAXC) m_ll = th + 1;
            th = 0;
            vr = vs && !vp;
            vp = vs;
            if (vr) begin
                if (lv < MAXC) m_fl = lv + 1;
                lv   = 0;
                m_fs = 1;
            end else begin
                lv++;
            end
        end else begin
            th++;
        end
        if (clampc(th) == MAXC || clampc(lv) == MAXC) begin
            srch = 1;
            run  = 0;
        end else if (m_fs) begin
            if (srch) begin
                srch   = 0;
                run    = 0;
                last_h = -1;
            end else if (m_fl == last_h) begin
                run++;
            end else begin
                last_h = m_fl;
                run    = 1;
            end
        end
    endtask

    task automatic compare_all();
        int hc, vc;
        bit hb, vb;
        hc = clampc(th);
        vc = clampc(lv);
        hb = (hc >= int'(hb_start)) || (hc < int'(hb_end));
        vb = (vc >= int'(vb_start)) || (vc < int'(vb_end));
        check("hcnt", 32'(hcnt), 32'(hc));
        check("vcnt", 32'(vcnt), 32'(vc));
        check("hsync", 32'(hsync), 32'(hp));
        check("vsync", 32'(vsync), 32'(vp));
        check("hblank", 32'(hblank), 32'(hb));
        check("vblank", 32'(vblank), 32'(vb));
        check("de", 32'(de), 32'(!(hb || vb)));
        check("line_len", 32'(line_len), 32'(m_ll));
        check("frame_lines", 32'(frame_lines), 32'(m_fl));
        check("frame_start", 32'(frame_start), 32'(m_fs));
        check("locked", 32'(locked), 32'(!srch && run >= LOCK_FRAMES));
    endtask

    task automatic drive(input bit hs, input bit vs);
        hs_in = (SYNC_POL != 0) ? hs : !hs;
        vs_in = (SYNC_POL != 0) ? vs : !vs;
    endtask

    task automatic do_tick(input bit hs, input bit vs);
        drive(hs, vs);
        for (int k = 1; k <= PIX_DIV; k++) begin
            @(posedge clk_sys);
            #1;
            check("ce_pix", 32'(ce_pix), 32'(k == PIX_DIV));
        end
        model_tick(hs, vs);
        compare_all();
    endtask

    task automatic do_reset();
        drive(0, 0);
        reset_n = 1'b0;
        #1;
        check("rst_ce_pix", 32'(ce_pix), 32'd0);
        check("rst_hsync", 32'(hsync), 32'd0);
        check("rst_vsync", 32'(vsync), 32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        check("rst_de", 32'(de), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_hblank", 32'(hblank), 32'd1);
        check("rst_vblank", 32'(vblank), 32'd1);
        check("rst_hcnt", 32'(hcnt), 32'd0);
        check("rst_vcnt", 32'(vcnt), 32'd0);
        check("rst_line_len", 32'(line_len), 32'd0);
        check("rst_frame_lines", 32'(frame_lines), 32'd0);
        model_reset();
        repeat (2) @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
    endtask

    // Runs nl lines of an h-line frame; hs pulse 3 ticks, vs on lines 0..1.
    task automatic run_frame(input int h, input int nl, input bit rnd);
        int len;
        for (int l = 0; l < nl && l < h; l++) begin
            len = rnd ? int'($urandom_range(20, 30)) : 24;
            for (int t = 0; t < len; t++) do_tick(t < 3, l < 2);
        end
    endtask

    initial begin
        int h;
        hb_start = CNT_W'($urandom_range(15, 22));
        hb_end   = CNT_W'($urandom_range(0, 5));
        vb_start = CNT_W'($urandom_range(7, 10));
        vb_end   = CNT_W'($urandom_range(0, 2));
        @(posedge clk_sys);
        #1;
        do_reset();

        h = 10;
        for (int f = 0; f < 14; f++) begin
            if ($urandom_range(0, 3) == 0) h = int'($urandom_range(9, 12));
            run_frame(h, h, 1'b1);
        end

        hb_start = CNT_W'($urandom_range(15, 22));
        vb_end   = CNT_W'($urandom_range(0, 2));
        for (int f = 0; f < 5; f++) run_frame(10, 10, 1'b1);
        for (int f = 0; f < 4; f++) run_frame(11, 11, 1'b1);

        for (int t = 0; t < 1100; t++) do_tick(0, 0);
        for (int f = 0; f < 5; f++) run_frame(10, 10, 1'b1);

        run_frame(10, 5, 1'b1);
        do_reset();
        for (int f = 0; f < 6; f++) run_frame(10, 10, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
